// File: rtl/vote_pkg.sv
// Shared definitions for the five-voter majority sequencer.
//   state_e         : sequencer states (2-bit encoding)
//   NUM_VOTERS      : ballots per round
//   MAJORITY_THRESH : minimum number of 1-ballots for a 1 result
//   CNT_W           : width of the ballot counter and popcount
package vote_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StEval    = 2'd2,
    StShow    = 2'd3
  } state_e;

  localparam int unsigned NUM_VOTERS      = 5;
  localparam int unsigned MAJORITY_THRESH = 3;
  localparam int unsigned CNT_W           = 3;

  // Number of set bits among the five ballots.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_VOTERS-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and rising-edge pulse.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   btn   : raw asynchronous, bouncy button level
//   pulse : one-cycle pulse on each rising edge of the debounced level,
//           DEBOUNCE_CYCLES+3 cycles after a stable raw edge
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic            pulse_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter tracks how many consecutive synchronized samples have
  // disagreed with the debounced level; any agreeing sample restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      pulse_q     <= level_q & ~level_dly_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/vote_sequencer.sv
// Five-voter majority vote sequencer for the Boolean Board.
//   clk        : system clock (100 MHz)
//   rst        : synchronous active-high reset
//   btn_cast   : raw cast button
//   btn_clear  : raw clear button
//   sw_vote    : ballot value, sampled when the cast pulse fires
//   ballot_led : captured ballots, bit i = ballot i
//   count_led  : ballots captured so far, 0..5
//   result_led : majority result, meaningful while valid_led=1
//   valid_led  : result is being held
//   err_led    : previous round was aborted by timeout
module vote_sequencer
  import vote_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_cast,
  input  logic                  btn_clear,
  input  logic                  sw_vote,
  output logic [NUM_VOTERS-1:0] ballot_led,
  output logic [CNT_W-1:0]      count_led,
  output logic                  result_led,
  output logic                  valid_led,
  output logic                  err_led
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_VOTERS - 1);

  logic cast_p, clear_p;
  logic sw_sync1_q, sw_sync2_q;

  state_e                state_q, state_d;
  logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  tmo_hit;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cast_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_cast),
    .pulse(cast_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_clear),
    .pulse(clear_p)
  );

  assign tmo_hit = (tmo_q == TmoMax);

  // State register plus the registered datapath that drives the LEDs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync1_q <= 1'b0;
      sw_sync2_q <= 1'b0;
      state_q    <= StIdle;
      ballot_q   <= '0;
      count_q    <= '0;
      result_q   <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      sw_sync1_q <= sw_vote;
      sw_sync2_q <= sw_sync1_q;
      state_q    <= state_d;
      ballot_q   <= ballot_d;
      count_q    <= count_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state logic. Clear beats cast; cast beats timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!clear_p && cast_p) state_d = StCollect;
      end
      StCollect: begin
        if (clear_p) begin
          state_d = StIdle;
        end else if (cast_p) begin
          if (count_q == LastIdx) state_d = StEval;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StEval: state_d = StShow;
      StShow: begin
        if (clear_p) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; the timeout counter only advances in collect.
  always_comb begin
    ballot_d = ballot_q;
    count_d  = count_q;
    result_d = result_q;
    valid_d  = valid_q;
    err_d    = err_q;
    tmo_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (clear_p) begin
          err_d = 1'b0;
        end else if (cast_p) begin
          ballot_d = NUM_VOTERS'(sw_sync2_q);
          count_d  = CNT_W'(1);
          err_d    = 1'b0;
        end
      end
      StCollect: begin
        if (clear_p) begin
          ballot_d = '0;
          count_d  = '0;
        end else if (cast_p) begin
          ballot_d = ballot_q | (NUM_VOTERS'(sw_sync2_q) << count_q);
          count_d  = count_q + CNT_W'(1);
        end else if (tmo_hit) begin
          ballot_d = '0;
          count_d  = '0;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StEval: begin
        result_d = (popcount(ballot_q) >= CNT_W'(MAJORITY_THRESH));
        valid_d  = 1'b1;
      end
      StShow: begin
        if (clear_p) begin
          ballot_d = '0;
          count_d  = '0;
          result_d = 1'b0;
          valid_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign ballot_led = ballot_q;
  assign count_led  = count_q;
  assign result_led = result_q;
  assign valid_led  = valid_q;
  assign err_led    = err_q;

endmodule

// File: tb/tb_vote_sequencer.sv
// Self-checking bench for vote_sequencer with a round-level reference model.
module tb_vote_sequencer;

  localparam int unsigned D    = 4;
  localparam int unsigned T    = 50;
  localparam int unsigned HOLD = D + 8;
  localparam int unsigned REL  = D + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_cast = 1'b0;
  logic       btn_clear = 1'b0;
  logic       sw_vote = 1'b0;
  logic [4:0] ballot_led;
  logic [2:0] count_led;
  logic       result_led, valid_led, err_led;
  logic [10:0] act;

  int n_checks = 0;
  int n_errors = 0;

  // Round-level model: list of ballots cast, whether a result is shown, error flag.
  bit mq[$];
  bit m_show, m_res, m_err;

  vote_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_cast  (btn_cast),
    .btn_clear (btn_clear),
    .sw_vote   (sw_vote),
    .ballot_led(ballot_led),
    .count_led (count_led),
    .result_led(result_led),
    .valid_led (valid_led),
    .err_led   (err_led)
  );

  always #5 clk = ~clk;

  assign act = {ballot_led, count_led, result_led, valid_led, err_led};

  function automatic void m_reset();
    mq.delete();
    m_show = 0;
    m_res  = 0;
    m_err  = 0;
  endfunction

  function automatic void m_cast(bit v);
    int s;
    if (m_show) return;
    if (mq.size() == 0) m_err = 0;
    mq.push_back(v);
    if (mq.size() == 5) begin
      s = 0;
      foreach (mq[i]) s += int'(mq[i]);
      m_res  = (s >= 3);
      m_show = 1;
    end
  endfunction

  function automatic void m_clear();
    m_reset();
  endfunction

  function automatic void m_timeout();
    if (!m_show && mq.size() > 0) begin
      mq.delete();
      m_err = 1;
    end
  endfunction

  // Expected {ballot, count, result, valid, err}.
  function automatic logic [10:0] exp_vec();
    logic [4:0] b;
    b = '0;
    foreach (mq[i]) b[i] = mq[i];
    return {b, 3'(mq.size()), m_show & m_res, m_show, m_err};
  endfunction

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit do_cast, input bit do_clear, input bit v);
    sw_vote = v;
    cycles(3);
    btn_cast  = do_cast;
    btn_clear = do_clear;
    cycles(HOLD);
    btn_cast  = 1'b0;
    btn_clear = 1'b0;
    cycles(REL);
  endtask

  task automatic hold_cast(input bit lvl, input int unsigned n);
    btn_cast = lvl;
    cycles(n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    m_reset();
    cycles(1);
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected %b", act, exp_vec());
    end
  endtask

  task automatic test_majority_yes();
    bit votes[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    foreach (votes[i]) begin
      press(1, 0, votes[i]);
      m_cast(votes[i]);
      n_checks++;
      if (act !== exp_vec()) begin
        n_errors++;
        $display("FAIL yes_cast%0d: got %b expected %b", i, act, exp_vec());
      end
    end
    // Fifth ballot with exact latency checks.
    sw_vote = 1'b0;
    cycles(3);
    btn_cast = 1'b1;
    cycles(D + 3);
    n_checks++;
    if (count_led !== 3'd4) begin
      n_errors++;
      $display("FAIL yes_early_count: got %0d expected 4", count_led);
    end
    cycles(1);
    n_checks++;
    if (count_led !== 3'd5 || valid_led !== 1'b0) begin
      n_errors++;
      $display("FAIL yes_count5: got count %0d valid %b expected count 5 valid 0",
               count_led, valid_led);
    end
    cycles(1);
    m_cast(1'b0);
    n_checks++;
    if (ballot_led !== 5'b01101 || result_led !== 1'b1 || valid_led !== 1'b1) begin
      n_errors++;
      $display("FAIL yes_result: got ballot %b res %b valid %b expected 01101 1 1",
               ballot_led, result_led, valid_led);
    end
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL yes_model: got %b expected %b", act, exp_vec());
    end
    cycles(HOLD - D - 5);
    btn_cast = 1'b0;
    cycles(REL);
    press(0, 1, 0);
    m_clear();
  endtask

  task automatic test_majority_no_clear();
    bit votes[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    foreach (votes[i]) begin
      press(1, 0, votes[i]);
      m_cast(votes[i]);
    end
    n_checks++;
    if (ballot_led !== 5'b10100 || result_led !== 1'b0 || valid_led !== 1'b1) begin
      n_errors++;
      $display("FAIL no_result: got ballot %b res %b valid %b expected 10100 0 1",
               ballot_led, result_led, valid_led);
    end
    press(0, 1, 0);
    m_clear();
    n_checks++;
    if (act !== 11'd0) begin
      n_errors++;
      $display("FAIL no_clear: got %b expected %b", act, 11'd0);
    end
  endtask

  task automatic test_bounce();
    hold_cast(1, 3);
    hold_cast(0, 20);
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL short_glitch: got %b expected %b", act, exp_vec());
    end
    sw_vote = 1'b1;
    cycles(3);
    hold_cast(1, 1);
    hold_cast(0, 1);
    hold_cast(1, 2);
    hold_cast(0, 1);
    hold_cast(1, 3);
    hold_cast(0, 2);
    hold_cast(1, HOLD);
    hold_cast(0, 1);
    hold_cast(1, 2);
    hold_cast(0, REL);
    m_cast(1'b1);
    n_checks++;
    if (count_led !== 3'd1 || act !== exp_vec()) begin
      n_errors++;
      $display("FAIL bounce_one_ballot: got %b expected %b", act, exp_vec());
    end
    press(0, 1, 0);
    m_clear();
  endtask

  task automatic test_timeout();
    bit v;
    for (int i = 0; i < 2; i++) begin
      v = 1'($urandom_range(0, 1));
      press(1, 0, v);
      m_cast(v);
    end
    // Second ballot was captured 16 cycles ago; abort lands 50 cycles after capture.
    cycles(33);
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL timeout_early: got %b expected %b", act, exp_vec());
    end
    cycles(1);
    m_timeout();
    n_checks++;
    if (err_led !== 1'b1 || act !== exp_vec()) begin
      n_errors++;
      $display("FAIL timeout_abort: got %b expected %b", act, exp_vec());
    end
    v = 1'($urandom_range(0, 1));
    press(1, 0, v);
    m_cast(v);
    n_checks++;
    if (err_led !== 1'b0 || act !== exp_vec()) begin
      n_errors++;
      $display("FAIL timeout_recover: got %b expected %b", act, exp_vec());
    end
    press(0, 1, 0);
    m_clear();
  endtask

  task automatic test_cast_clear_same();
    bit v;
    for (int i = 0; i < 3; i++) begin
      v = 1'($urandom_range(0, 1));
      press(1, 0, v);
      m_cast(v);
    end
    press(1, 1, 1);
    m_clear();
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL cast_clear_same: got %b expected %b", act, exp_vec());
    end
    press(1, 0, 1);
    m_cast(1'b1);
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL after_same_idle: got %b expected %b", act, exp_vec());
    end
    press(0, 1, 0);
    m_clear();
  endtask

  task automatic test_show_and_reset();
    bit v;
    for (int i = 0; i < 5; i++) begin
      v = 1'($urandom_range(0, 1));
      press(1, 0, v);
      m_cast(v);
    end
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL show_result: got %b expected %b", act, exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      v = 1'($urandom_range(0, 1));
      press(1, 0, v);
      m_cast(v);
    end
    n_checks++;
    if (act !== exp_vec()) begin
      n_errors++;
      $display("FAIL show_extra_casts: got %b expected %b", act, exp_vec());
    end
    press(0, 1, 0);
    m_clear();
    press(1, 0, 1);
    m_cast(1'b1);
    press(1, 0, 1);
    m_cast(1'b1);
    rst = 1'b1;
    cycles(1);
    m_reset();
    n_checks++;
    if (act !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_mid_collect: got %b expected %b", act, 11'd0);
    end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_random_rounds();
    int unsigned n;
    bit v;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 7);
      for (int k = 0; k < int'(n); k++) begin
        v = 1'($urandom_range(0, 1));
        press(1, 0, v);
        m_cast(v);
        n_checks++;
        if (act !== exp_vec()) begin
          n_errors++;
          $display("FAIL rand_r%0d_c%0d: got %b expected %b", r, k, act, exp_vec());
        end
      end
      press(0, 1, 0);
      m_clear();
      n_checks++;
      if (act !== exp_vec()) begin
        n_errors++;
        $display("FAIL rand_r%0d_clear: got %b expected %b", r, act, exp_vec());
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_majority_yes();
    test_majority_no_clear();
    test_bounce();
    test_timeout();
    test_cast_clear_same();
    test_show_and_reset();
    test_random_rounds();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
